// File: rtl/mc_core_seq.sv
// Multi-cycle RV32I control sequencer with req/ack memory handshakes, bounded wait and sticky trap.
// Optional SEQ_PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module mc_core_seq #(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       alu_zero,
   output logic       imem_req,
   input  logic       imem_ack,
   output logic       dmem_req,
   output logic       dmem_we,
   input  logic       dmem_ack,
   output logic       pc_cur_write,
   output logic       pc_next_write,
   output logic [1:0] pc_update_sel,
   output logic       ir_write,
   output logic       regs_write,
   output logic [3:0] alu_op,
   output logic       alu_rhs_sel,
   output logic [1:0] wb_sel,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [3:0] watch_stat
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   typedef enum logic [3:0] {
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StExec   = 4'd3,
      StMem    = 4'd4,
      StWb     = 4'd5,
      StTrap   = 4'd15
   } state_e;

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cause_q, cause_d;

   logic is_r, is_i, is_lw, is_sw, is_br, is_lui, is_jal, is_jalr, legal;
   logic [3:0] alu_dec;
   logic       rhs_dec, taken, timeout;
   logic       unused_func7;

   assign unused_func7 = ^{func7[6], func7[4:0]};

   assign is_r    = (opcode == OpR);
   assign is_i    = (opcode == OpImm);
   assign is_lw   = (opcode == OpLoad)  && (func3 == 3'b010);
   assign is_sw   = (opcode == OpStore) && (func3 == 3'b010);
   assign is_br   = (opcode == OpBranch) && ((func3 == 3'b000) || (func3 == 3'b001));
   assign is_lui  = (opcode == OpLui);
   assign is_jal  = (opcode == OpJal);
   assign is_jalr = (opcode == OpJalr);
   assign legal   = is_r | is_i | is_lw | is_sw | is_br | is_lui | is_jal | is_jalr;

   assign rhs_dec = is_i | is_lw | is_sw | is_jalr;
   assign taken   = (func3 == 3'b000) ? alu_zero : ~alu_zero;
   assign timeout = (WAIT_MAX != 0) && (cnt_q == CNT_W'(WAIT_MAX));

   // Only shifts carry func7[5] as an ALU op bit for immediates (SRAI vs SRLI).
   always_comb begin
      alu_dec = 4'b0000;
      if (is_r) begin
         alu_dec = {func7[5], func3};
      end else if (is_i) begin
         alu_dec = {((func3 == 3'b001) || (func3 == 3'b101)) ? func7[5] : 1'b0, func3};
      end else if (is_br) begin
         alu_dec = 4'b1000;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cause_d       = cause_q;
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      pc_cur_write  = 1'b0;
      pc_next_write = 1'b0;
      pc_update_sel = 2'd0;
      ir_write      = 1'b0;
      regs_write    = 1'b0;
      alu_op        = 4'b0000;
      alu_rhs_sel   = 1'b0;
      wb_sel        = 2'd0;
      unique case (state_q)
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_write      = 1'b1;
               pc_next_write = 1'b1;
               state_d       = StDecode;
            end else if (timeout) begin
               state_d = StTrap;
               cause_d = 2'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDecode: begin
            if (!legal) begin
               state_d = StTrap;
               cause_d = 2'd2;
            end else if (is_lui) begin
               regs_write   = 1'b1;
               pc_cur_write = 1'b1;
               state_d      = StFetch;
            end else if (is_jal) begin
               regs_write    = 1'b1;
               wb_sel        = 2'd3;
               pc_cur_write  = 1'b1;
               pc_update_sel = 2'd1;
               state_d       = StFetch;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            alu_op      = alu_dec;
            alu_rhs_sel = rhs_dec;
            if (is_br) begin
               pc_cur_write  = 1'b1;
               pc_update_sel = taken ? 2'd1 : 2'd0;
               state_d       = StFetch;
            end else if (is_lw || is_sw) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            dmem_req    = 1'b1;
            dmem_we     = is_sw;
            alu_rhs_sel = rhs_dec;
            if (dmem_ack) begin
               if (is_sw) begin
                  pc_cur_write = 1'b1;
                  state_d      = StFetch;
               end else begin
                  state_d = StWb;
               end
            end else if (timeout) begin
               state_d = StTrap;
               cause_d = 2'd3;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StWb: begin
            regs_write    = 1'b1;
            alu_op        = alu_dec;
            alu_rhs_sel   = rhs_dec;
            pc_cur_write  = 1'b1;
            wb_sel        = is_lw ? 2'd2 : (is_jalr ? 2'd3 : 2'd1);
            pc_update_sel = is_jalr ? 2'd2 : 2'd0;
            state_d       = StFetch;
         end
         StTrap: begin
         end
         default: state_d = StFetch;
      endcase
      if ((state_d != state_q) && ((state_d == StFetch) || (state_d == StMem))) begin
         cnt_d = '0;
      end
      // Reset is asynchronous, so strobes must fall without waiting for the state register.
      if (!rst) begin
         imem_req      = 1'b0;
         dmem_req      = 1'b0;
         dmem_we       = 1'b0;
         pc_cur_write  = 1'b0;
         pc_next_write = 1'b0;
         ir_write      = 1'b0;
         regs_write    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StFetch;
         cnt_q   <= '0;
         cause_q <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   assign trap       = (state_q == StTrap);
   assign trap_cause = cause_q;
   assign watch_stat = state_q;

`ifdef SEQ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt   <= 32'd0;
         instret_cnt <= 32'd0;
      end else begin
         if (state_q != StTrap) begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end
         if ((state_d == StFetch) && (state_q != StFetch)) begin
            instret_cnt <= instret_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
